// File: rtl/register_file_pkg.sv
// Shared defaults for the register file: widths, depth, reset value and a
// selector range helper used by the top and its cells.
package register_file_pkg;

    localparam int   DEFAULT_DATA_WIDTH = 8;
    localparam int   DEFAULT_NUM_REGS   = 8;
    localparam logic RESET_BIT          = 1'b0;

    // True when a selector addresses a physically present register.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_regs);
        return (sel < num_regs);
    endfunction

endpackage

// File: rtl/register_file_cell.sv
// regfile_cell: one register with load (priority), increment and async reset.
// BYPASS selects whether value_o shows the held value or the next-edge value.
module regfile_cell
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic [DATA_WIDTH-1:0] value_o
);

    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] value_d;

    // Next value: a write overrides a same-cycle increment.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_data_i;
        end else if (inc_i) begin
            value_d = value_q + DATA_WIDTH'(1'b1);
        end else begin
            value_d = value_q;
        end
    end

    // Storage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= {DATA_WIDTH{RESET_BIT}};
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = BYPASS ? value_d : value_q;

endmodule

// File: rtl/register_file.sv
// register_file: NUM_REGS x DATA_WIDTH registers, one write, one increment and
// two registered read ports. Define REGFILE_BYPASS_EN for read-during-write bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inc_en,
    input  logic [ADDR_WIDTH-1:0] inc_sel,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_sel_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  rd_valid_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_sel_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid_b,
    output logic                  addr_err
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] src_s [NUM_REGS];
    logic                  wr_ok_s, inc_ok_s, a_ok_s, b_ok_s;
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic                  rd_valid_a_q, rd_valid_b_q, addr_err_q, addr_err_d;

    assign wr_ok_s  = sel_in_range(32'(wr_sel),   NUM_REGS);
    assign inc_ok_s = sel_in_range(32'(inc_sel),  NUM_REGS);
    assign a_ok_s   = sel_in_range(32'(rd_sel_a), NUM_REGS);
    assign b_ok_s   = sel_in_range(32'(rd_sel_b), NUM_REGS);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        regfile_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .BYPASS     (BYPASS)
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .load_i      (wr_en && (wr_sel == ADDR_WIDTH'(g))),
            .inc_i       (inc_en && (inc_sel == ADDR_WIDTH'(g))),
            .load_data_i (wr_data),
            .value_o     (src_s[g])
        );
    end

    // Read muxes: hold when idle, zero for an out-of-range selector.
    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_en_a) begin
            rd_data_a_d = a_ok_s ? src_s[rd_sel_a] : {DATA_WIDTH{1'b0}};
        end else begin
            rd_data_a_d = rd_data_a_q;
        end
        if (rd_en_b) begin
            rd_data_b_d = b_ok_s ? src_s[rd_sel_b] : {DATA_WIDTH{1'b0}};
        end else begin
            rd_data_b_d = rd_data_b_q;
        end
        addr_err_d = (wr_en && !wr_ok_s) || (inc_en && !inc_ok_s) ||
                     (rd_en_a && !a_ok_s) || (rd_en_b && !b_ok_s);
    end

    // Registered read ports and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a_q  <= {DATA_WIDTH{RESET_BIT}};
            rd_data_b_q  <= {DATA_WIDTH{RESET_BIT}};
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_en_a;
            rd_valid_b_q <= rd_en_b;
            addr_err_q   <= addr_err_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: an 8-register instance and a 6-register
// instance for out-of-range selectors.
module tb_register_file;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, inc_en, rd_en_a, rd_en_b;
    logic [2:0] wr_sel, inc_sel, rd_sel_a, rd_sel_b;
    logic [7:0] wr_data, rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b, addr_err;

    logic       s6_wr_en, s6_inc_en, s6_rd_en_a, s6_rd_en_b;
    logic [2:0] s6_wr_sel, s6_inc_sel, s6_rd_sel_a, s6_rd_sel_b;
    logic [7:0] s6_wr_data, s6_rd_data_a, s6_rd_data_b;
    logic       s6_rd_valid_a, s6_rd_valid_b, s6_addr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .inc_en(inc_en), .inc_sel(inc_sel),
        .rd_en_a(rd_en_a), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .addr_err(addr_err)
    );

    register_file #(.NUM_REGS(6)) dut6 (
        .clk(clk), .reset(reset),
        .wr_en(s6_wr_en), .wr_sel(s6_wr_sel), .wr_data(s6_wr_data),
        .inc_en(s6_inc_en), .inc_sel(s6_inc_sel),
        .rd_en_a(s6_rd_en_a), .rd_sel_a(s6_rd_sel_a), .rd_data_a(s6_rd_data_a), .rd_valid_a(s6_rd_valid_a),
        .rd_en_b(s6_rd_en_b), .rd_sel_b(s6_rd_sel_b), .rd_data_b(s6_rd_data_b), .rd_valid_b(s6_rd_valid_b),
        .addr_err(s6_addr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; inc_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
        s6_wr_en = 1'b0; s6_inc_en = 1'b0; s6_rd_en_a = 1'b0; s6_rd_en_b = 1'b0;
    endtask

    task automatic rd2(input logic [2:0] sa, input logic [2:0] sb);
        rd_en_a = 1'b1; rd_sel_a = sa;
        rd_en_b = 1'b1; rd_sel_b = sb;
    endtask

    logic [7:0] exp_r1, exp_r3;

    initial begin
        reset = 1'b1;
        wr_sel = 3'd0; wr_data = 8'h00; inc_sel = 3'd0; rd_sel_a = 3'd0; rd_sel_b = 3'd0;
        s6_wr_sel = 3'd0; s6_wr_data = 8'h00; s6_inc_sel = 3'd0; s6_rd_sel_a = 3'd0; s6_rd_sel_b = 3'd0;
        idle();
        #3;
        check_eq("rst_data_a", 32'(rd_data_a), 32'h0);
        check_eq("rst_valid_a", 32'(rd_valid_a), 32'h0);
        check_eq("rst_valid_b", 32'(rd_valid_b), 32'h0);
        check_eq("rst_addr_err", 32'(addr_err), 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // All registers read zero after reset, on both ports.
        for (int i = 0; i < 8; i++) begin
            rd2(3'(i), 3'(7 - i));
            tick();
            check_eq($sformatf("init_a_r%0d", i), 32'(rd_data_a), 32'h0);
            check_eq($sformatf("init_va_r%0d", i), 32'(rd_valid_a), 32'h1);
            check_eq($sformatf("init_b_r%0d", 7 - i), 32'(rd_data_b), 32'h0);
            check_eq($sformatf("init_vb_r%0d", 7 - i), 32'(rd_valid_b), 32'h1);
        end
        idle();

        // Write R3 then read it on both ports.
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 8'hA5;
        tick();
        idle(); rd2(3'd3, 3'd3);
        tick();
        check_eq("r3_a", 32'(rd_data_a), 32'hA5);
        check_eq("r3_b", 32'(rd_data_b), 32'hA5);
        idle();
        tick();
        check_eq("idle_valid_a", 32'(rd_valid_a), 32'h0);
        check_eq("idle_valid_b", 32'(rd_valid_b), 32'h0);
        check_eq("idle_hold_a", 32'(rd_data_a), 32'hA5);

        // Wrap R7, write-wins on R2, write/inc on different registers.
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'hFF;
        tick();
        idle(); inc_en = 1'b1; inc_sel = 3'd7;
        tick();
        idle(); wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h10; inc_en = 1'b1; inc_sel = 3'd2;
        tick();
        idle(); wr_en = 1'b1; wr_sel = 3'd5; wr_data = 8'h33; inc_en = 1'b1; inc_sel = 3'd6;
        tick();
        idle(); rd2(3'd2, 3'd5);
        tick();
        check_eq("r2_write_wins", 32'(rd_data_a), 32'h10);
        check_eq("r5_write", 32'(rd_data_b), 32'h33);
        rd2(3'd6, 3'd7);
        tick();
        check_eq("r6_inc", 32'(rd_data_a), 32'h01);
        check_eq("r7_wrap", 32'(rd_data_b), 32'h00);

        // Read during write / increment at the same edge.
`ifdef REGFILE_BYPASS_EN
        exp_r1 = 8'h5A; exp_r3 = 8'hA6;
`else
        exp_r1 = 8'h00; exp_r3 = 8'hA5;
`endif
        idle(); wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h5A; inc_en = 1'b1; inc_sel = 3'd3;
        rd2(3'd1, 3'd3);
        tick();
        check_eq("rdw_r1", 32'(rd_data_a), 32'(exp_r1));
        check_eq("rdw_r3", 32'(rd_data_b), 32'(exp_r3));
        idle(); rd2(3'd1, 3'd3);
        tick();
        check_eq("after_r1", 32'(rd_data_a), 32'h5A);
        check_eq("after_r3", 32'(rd_data_b), 32'hA6);
        check_eq("inrange_no_err", 32'(addr_err), 32'h0);
        idle();

        // Six-register instance: out-of-range write and read.
        s6_wr_en = 1'b1; s6_wr_sel = 3'd7; s6_wr_data = 8'h99;
        s6_rd_en_a = 1'b1; s6_rd_sel_a = 3'd6;
        tick();
        check_eq("oor_rd_data", 32'(s6_rd_data_a), 32'h0);
        check_eq("oor_rd_valid", 32'(s6_rd_valid_a), 32'h1);
        check_eq("oor_addr_err", 32'(s6_addr_err), 32'h1);
        idle();
        tick();
        check_eq("oor_err_clears", 32'(s6_addr_err), 32'h0);
        s6_inc_en = 1'b1; s6_inc_sel = 3'd6;
        tick();
        check_eq("oor_inc_err", 32'(s6_addr_err), 32'h1);
        idle();
        for (int i = 0; i < 6; i++) begin
            s6_rd_en_a = 1'b1; s6_rd_sel_a = 3'(i);
            tick();
            check_eq($sformatf("oor_no_alias_r%0d", i), 32'(s6_rd_data_a), 32'h0);
            check_eq($sformatf("oor_ok_err_r%0d", i), 32'(s6_addr_err), 32'h0);
        end
        idle();

        // Reset between edges during a write to R4.
        wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h44;
        rd2(3'd1, 3'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_data_a", 32'(rd_data_a), 32'h0);
        check_eq("midrst_data_b", 32'(rd_data_b), 32'h0);
        check_eq("midrst_valid_a", 32'(rd_valid_a), 32'h0);
        @(posedge clk);
        #2;
        idle();
        reset = 1'b0;
        rd2(3'd4, 3'd3);
        tick();
        check_eq("post_rst_r4", 32'(rd_data_a), 32'h0);
        check_eq("post_rst_r3", 32'(rd_data_b), 32'h0);
        check_eq("post_rst_valid", 32'(rd_valid_a), 32'h1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
